// File: rtl/pulse_pkg.sv
// Shared types for the pulse-descriptor path: descriptor layout, sequencer states, memory word layout.
// Width macros mirror pulse_descriptor.vh and are only defaulted here when that header is absent.
`ifndef PULSE_REG_TSTART_W
`define PULSE_REG_TSTART_W 16
`endif
`ifndef PULSE_MEM_ADDR_W
`define PULSE_MEM_ADDR_W 8
`endif

package pulse_pkg;

    localparam int unsigned DESC_DELAY_W = `PULSE_REG_TSTART_W;
    localparam int unsigned DESC_ADDR_W  = `PULSE_MEM_ADDR_W;
    localparam int unsigned SAMPLE_W_DEF = 16;
    // Pulse memory word: {last, sample[SAMPLE_W-1:0]}
    localparam int unsigned LAST_BIT     = SAMPLE_W_DEF;

    typedef struct packed {
        logic [DESC_DELAY_W-1:0] delay;
        logic [DESC_ADDR_W-1:0]  pulse_mem_addr;
    } pulse_descriptor_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pulse_delay_timer.sv
// Loadable down-counter with a zero flag; times the WAIT interval of the pulse sequencer.
module pulse_delay_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Pops {delay, addr} descriptors, waits delay cycles, then streams pulse memory until a last-tagged word.
// Optional PULSE_SEQ_STATS_EN adds pulse_count / sample_count outputs.
`ifndef PULSE_REG_TSTART_W
`define PULSE_REG_TSTART_W 16
`endif
`ifndef PULSE_MEM_ADDR_W
`define PULSE_MEM_ADDR_W 8
`endif

module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int unsigned DELAY_W  = `PULSE_REG_TSTART_W,
    parameter int unsigned ADDR_W   = `PULSE_MEM_ADDR_W,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned MAX_LEN  = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                desc_empty,
    input  logic [DELAY_W-1:0]  desc_delay,
    input  logic [ADDR_W-1:0]   desc_addr,
    output logic                desc_rd_en,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [SAMPLE_W:0]   mem_rdata,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
`ifdef PULSE_SEQ_STATS_EN
    output logic [31:0]         pulse_count,
    output logic [31:0]         sample_count,
`endif
    output logic                len_err
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    seq_state_e          state_q;
    seq_state_e          state_d;
    seq_state_e          start_state;
    logic                pop;
    logic                timer_zero;
    logic                last_flag;
    logic                len_hit;
    logic                pulse_end;

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                rd_pending_q;
    logic                rd_pending_d;
    logic [LEN_W-1:0]    len_cnt_q;
    logic [LEN_W-1:0]    len_cnt_d;
    logic                len_err_q;
    logic                len_err_d;

    // Timer is loaded with delay-1 so its zero flag marks the last WAIT cycle.
    pulse_delay_timer #(
        .W (DELAY_W)
    ) u_delay_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (pop && (desc_delay != '0)),
        .load_val (desc_delay - 1'b1),
        .dec      (state_q == ST_WAIT),
        .zero     (timer_zero)
    );

    always_comb begin
        last_flag = mem_rdata[SAMPLE_W];
        len_hit   = (len_cnt_q == LEN_W'(MAX_LEN - 1));
        pulse_end = rd_pending_q && (last_flag || len_hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        start_state = (desc_delay == '0) ? ST_PLAY : ST_WAIT;
        case (state_q)
            ST_IDLE: begin
                if (!desc_empty) begin
                    pop     = 1'b1;
                    state_d = start_state;
                end
            end
            ST_WAIT: begin
                if (timer_zero) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (pulse_end) begin
                    if (!desc_empty) begin
                        pop     = 1'b1;
                        state_d = start_state;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The read issued alongside the final sample never becomes a pending sample.
    always_comb begin
        addr_d       = addr_q;
        len_cnt_d    = len_cnt_q;
        rd_pending_d = (state_q == ST_PLAY) && !pulse_end;
        len_err_d    = len_err_q | (rd_pending_q && len_hit && !last_flag);
        if (pop) begin
            addr_d    = desc_addr;
            len_cnt_d = '0;
        end else begin
            if (state_q == ST_PLAY) begin
                addr_d = addr_q + 1'b1;
            end
            if (rd_pending_q) begin
                len_cnt_d = len_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            rd_pending_q <= 1'b0;
            len_cnt_q    <= '0;
            len_err_q    <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            rd_pending_q <= rd_pending_d;
            len_cnt_q    <= len_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

`ifdef PULSE_SEQ_STATS_EN
    logic [31:0] pulse_cnt_q;
    logic [31:0] pulse_cnt_d;
    logic [31:0] sample_cnt_q;
    logic [31:0] sample_cnt_d;

    always_comb begin
        pulse_cnt_d  = pulse_cnt_q + {31'd0, pulse_end};
        sample_cnt_d = sample_cnt_q + {31'd0, rd_pending_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt_q  <= '0;
            sample_cnt_q <= '0;
        end else begin
            pulse_cnt_q  <= pulse_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign pulse_count  = pulse_cnt_q;
    assign sample_count = sample_cnt_q;
`endif

    // Pop is masked by reset so a pending FIFO head is never consumed while held in reset.
    always_comb begin
        desc_rd_en   = pop && !reset;
        mem_rd_en    = (state_q == ST_PLAY);
        mem_addr     = (state_q == ST_PLAY) ? addr_q : '0;
        sample_valid = rd_pending_q;
        sample_out   = rd_pending_q ? mem_rdata[SAMPLE_W-1:0] : '0;
        busy         = (state_q != ST_IDLE);
        len_err      = len_err_q;
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: schedule-based reference model plus directed scenarios.
// Build with PULSE_SEQ_STATS_EN defined to also check the statistics counters.
module tb_pulse_sequencer;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int SW  = 16;
    localparam int ML  = 8;
    localparam int NC  = 4096;
    localparam int BIG = 1 << 30;

    logic          clk;
    logic          reset;
    logic          desc_empty;
    logic [DW-1:0] desc_delay;
    logic [AW-1:0] desc_addr;
    logic          desc_rd_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [SW:0]   mem_rdata = '0;
    logic [SW-1:0] sample_out;
    logic          sample_valid;
    logic          busy;
    logic          len_err;
`ifdef PULSE_SEQ_STATS_EN
    logic [31:0]   pulse_count;
    logic [31:0]   sample_count;
`endif

    pulse_sequencer #(
        .DELAY_W  (DW),
        .ADDR_W   (AW),
        .SAMPLE_W (SW),
        .MAX_LEN  (ML)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .desc_empty   (desc_empty),
        .desc_delay   (desc_delay),
        .desc_addr    (desc_addr),
        .desc_rd_en   (desc_rd_en),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
`ifdef PULSE_SEQ_STATS_EN
        .pulse_count  (pulse_count),
        .sample_count (sample_count),
`endif
        .len_err      (len_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: synchronous pulse memory and a show-ahead descriptor FIFO.
    logic [SW:0]   mem [256];
    logic [DW-1:0] fq_delay [16];
    logic [AW-1:0] fq_addr  [16];
    int            head = 0;
    int            tail = 0;

    assign desc_empty = (head == tail);
    assign desc_delay = fq_delay[head[3:0]];
    assign desc_addr  = fq_addr[head[3:0]];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (desc_rd_en) head <= head + 1;
    end

    // Reference model: every popped descriptor is expanded into a per-cycle schedule.
    int            md [32];
    int            ma [32];
    int            np = 0;
    int            mc = 0;
    bit            e_pop  [NC];
    bit            e_rd   [NC];
    bit            e_sv   [NC];
    bit            e_busy [NC];
    bit            e_done [NC];
    logic [AW-1:0] e_addr [NC];
    logic [SW-1:0] e_smp  [NC];
    int            end_c = -10;
    int            lerr_from = BIG;
    int            exp_samples = 0;
    int            exp_pulses = 0;
    int            pop_log [32];
    int            npops = 0;
    int            cyc = 0;
    int            obs_sv = 0;
    int            n_checks = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [SW:0] word_at(input int i);
        return mem[i[7:0]];
    endfunction

    task automatic plan_pulse(input int t, input int d, input int a);
        int  n;
        bit  found;
        int  e;
        n     = ML;
        found = 1'b0;
        for (int k = 0; k < ML; k++) begin
            if (!found && word_at(a + k)[SW]) begin
                n     = k + 1;
                found = 1'b1;
            end
        end
        e = t + 1 + d + n;
        e_pop[t] = 1'b1;
        for (int k = 0; k <= n; k++) begin
            e_rd[t + 1 + d + k]   = 1'b1;
            e_addr[t + 1 + d + k] = AW'(a + k);
        end
        for (int k = 0; k < n; k++) begin
            e_sv[t + 2 + d + k]  = 1'b1;
            e_smp[t + 2 + d + k] = word_at(a + k)[SW-1:0];
        end
        for (int i = t + 1; i <= e + 1; i++) e_busy[i] = 1'b1;
        e_done[e] = 1'b1;
        end_c = e;
        if (!found && (lerr_from > e + 1)) lerr_from = e + 1;
        pop_log[npops] = t;
        npops++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                for (int i = cyc; i < NC; i++) begin
                    e_pop[i] = 0; e_rd[i] = 0; e_sv[i] = 0; e_busy[i] = 0; e_done[i] = 0;
                    e_addr[i] = '0; e_smp[i] = '0;
                end
                end_c       = -10;
                lerr_from   = BIG;
                exp_samples = 0;
                exp_pulses  = 0;
            end else if (((cyc == end_c) || (cyc >= end_c + 2)) && (mc < np)) begin
                plan_pulse(cyc, md[mc], ma[mc]);
                mc++;
            end
            chk("desc_rd_en",   32'(desc_rd_en),   32'(e_pop[cyc]));
            chk("mem_rd_en",    32'(mem_rd_en),    32'(e_rd[cyc]));
            chk("mem_addr",     32'(mem_addr),     e_rd[cyc] ? 32'(e_addr[cyc]) : 32'd0);
            chk("sample_valid", 32'(sample_valid), 32'(e_sv[cyc]));
            chk("sample_out",   32'(sample_out),   e_sv[cyc] ? 32'(e_smp[cyc]) : 32'd0);
            chk("busy",         32'(busy),         32'(e_busy[cyc]));
            chk("len_err",      32'(len_err),      32'(cyc >= lerr_from));
`ifdef PULSE_SEQ_STATS_EN
            chk("pulse_count",  pulse_count,       32'(exp_pulses));
            chk("sample_count", sample_count,      32'(exp_samples));
`endif
            if (sample_valid) obs_sv++;
            exp_samples += int'(e_sv[cyc]);
            if (e_done[cyc]) exp_pulses++;
            cyc++;
        end
    end

    task automatic push(input int d, input int a);
        fq_delay[tail[3:0]] = DW'(d);
        fq_addr[tail[3:0]]  = AW'(a);
        md[np] = d;
        ma[np] = a;
        np++;
        tail++;
    endtask

    initial begin
        int p;
        int p1;
        int obs0;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, 8'(i), 8'hC5};
        for (int i = 0; i < 16; i++) begin
            fq_delay[i] = '0;
            fq_addr[i]  = '0;
        end
        mem[8'h10] = {1'b0, 16'h1010};
        mem[8'h11] = {1'b0, 16'h1011};
        mem[8'h12] = {1'b1, 16'h1012};
        mem[8'h20] = {1'b1, 16'h2020};
        mem[8'h30] = {1'b0, 16'h3030};
        mem[8'h31] = {1'b1, 16'h3031};
        mem[8'h40] = {1'b0, 16'h4040};
        mem[8'h41] = {1'b1, 16'h4041};
        mem[8'hFE] = {1'b0, 16'h0AFE};
        mem[8'hFF] = {1'b0, 16'h0AFF};
        mem[8'h00] = {1'b0, 16'hA000};
        mem[8'h01] = {1'b1, 16'hA001};
        mem[8'h85] = {1'b1, 16'h8585};
        mem[8'h90] = {1'b1, 16'h9090};
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single descriptor with delay 3
        push(3, 8'h10);
        repeat (15) @(negedge clk);
        p = pop_log[0];
        chk("t1_read_not_early", 32'(e_rd[p + 3]), 32'd0);
        chk("t1_first_read",     32'(e_rd[p + 4]), 32'd1);
        chk("t1_first_sample",   32'(e_smp[p + 5]), 32'h1010);
        chk("t1_last_sample",    32'(e_smp[p + 7]), 32'h1012);
        chk("t1_discard_read",   32'(e_rd[p + 7]), 32'd1);
        chk("t1_no_extra_sv",    32'(e_sv[p + 8]), 32'd0);
        chk("t1_busy_drain",     32'(e_busy[p + 8]), 32'd1);
        chk("t1_idle",           32'(e_busy[p + 9]), 32'd0);

        // One-word pulse, no delay
        push(0, 8'h20);
        repeat (10) @(negedge clk);
        p = pop_log[1];
        chk("t2_first_read",  32'(e_rd[p + 1]), 32'd1);
        chk("t2_sample",      32'(e_smp[p + 2]), 32'h2020);
        chk("t2_drain_busy",  32'(e_busy[p + 3]), 32'd1);
        chk("t2_idle",        32'(e_busy[p + 4]), 32'd0);

        // Back-to-back zero-delay pulses
        push(0, 8'h30);
        push(0, 8'h40);
        repeat (14) @(negedge clk);
        p  = pop_log[2];
        p1 = pop_log[3];
        chk("t3_pop_spacing", 32'(p1 - p), 32'd3);
        chk("t3_gap",         32'(e_sv[p1 + 1]), 32'd0);
        chk("t3_next_first",  32'(e_smp[p1 + 2]), 32'h4040);

        // Address wrap
        push(0, 8'hFE);
        repeat (12) @(negedge clk);
        p = pop_log[4];
        chk("t4_addr0", 32'(e_addr[p + 1]), 32'hFE);
        chk("t4_addr1", 32'(e_addr[p + 2]), 32'hFF);
        chk("t4_addr2", 32'(e_addr[p + 3]), 32'h00);
        chk("t4_addr3", 32'(e_addr[p + 4]), 32'h01);

        // No last flag: MAX_LEN abort
        obs0 = obs_sv;
        push(0, 8'h60);
        repeat (16) @(negedge clk);
        p = pop_log[5];
        chk("t5_lerr_cycle",  32'(lerr_from - p), 32'd10);
        chk("t5_sample_cnt",  32'(obs_sv - obs0), 32'd8);
        chk("t5_len_err",     32'(len_err), 32'd1);
        repeat (10) @(negedge clk);
        chk("t5_len_err_held", 32'(len_err), 32'd1);

        // Reset in the middle of PLAY
        push(0, 8'h80);
        push(1, 8'h90);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("t6_fifo_held",   32'(head), 32'd7);
        chk("t6_len_err_clr", 32'(len_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        p = pop_log[7];
        chk("t6_replay_sample", 32'(e_smp[p + 3]), 32'h9090);
        chk("t6_fifo_drained",  32'(head), 32'd8);
        #3;
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
